instr_fetch_buffer: RTL
=======================

Name: instr_fetch_buffer

Overview:
- Instruction-fetch front end. Consumes the architectural fetch address stream and issues in-order requests to the instruction memory over a req/gnt + rvalid interface.
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- On redirect (branch/jump/exception), it flushes buffered words, discards in-flight responses and restarts fetch at the new PC.

Parameters:
DEPTH, 4, buffer entries and max outstanding+buffered fetches (power of 2, >=2)
RESET_PC, 32'h00003000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
redirect_valid  in  1  redirect request this cycle
redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
mem_req  out  1  fetch request valid
mem_addr  out  32  fetch word address
mem_gnt  in  1  request accepted when mem_req && mem_gnt
mem_rvalid  in  1  response valid (one per granted request, in order, >=1 cycle after grant)
mem_rdata  in  32  instruction word
instr_valid  out  1  instruction available to decode
instr  out  32  instruction word at FIFO head
instr_pc  out  32  PC of instr
instr_ready  in  1  decode accepts when instr_valid && instr_ready

Behaviour:
- Reset (reset==0, asynchronous): fetch_pc=RESET_PC; FIFO count=0; live=0; drop=0; address-tag FIFO empty.
  - Outputs during reset: mem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - Memory system shares the same reset; responses to pre-reset grants never arrive.
- Counters:
  - live = granted requests whose responses are still wanted.
  - drop = granted requests whose responses must be discarded.
  - count = FIFO occupancy.
- Issue:
  - mem_req = !redirect_valid && (live+drop+count < DEPTH).
  - mem_addr = fetch_pc.
  - On grant: push fetch_pc into the tag FIFO, live+=1, fetch_pc+=4 (wraps modulo 2^32).
  - mem_addr is held stable while mem_req && !mem_gnt.
- Response (mem_rvalid):
  - If drop>0: drop-=1, data discarded.
  - Else: pop tag, push {tag, mem_rdata} into the FIFO, live-=1, count+=1.
  - The credit rule guarantees the FIFO never overflows on response.
- Output:
  - instr_valid = (count!=0) && !redirect_valid.
  - instr/instr_pc = FIFO head, combinational; zero when empty.
  - Pop on instr_valid && instr_ready.
  - Same-cycle push and pop: both happen, count unchanged.
  - Latency: a response at edge N is visible as instr_valid after edge N; no bypass from mem_rdata to instr.
- Redirect (redirect_valid==1, takes priority over everything):
  - FIFO cleared (count=0), tag FIFO cleared.
  - drop = drop + live − (mem_rvalid ? 1 : 0); live=0.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - No grant possible that cycle (mem_req=0).
  - Any decode handshake that cycle is void (instr_valid=0).
  - Back-to-back redirects: last one wins; drop accumulates correctly.
- Full: when live+drop+count==DEPTH, mem_req=0 until a pop or a dropped response frees a credit. The credit frees the next cycle; there is no combinational ready→req path.
- Empty: instr_valid=0; instr_ready ignored.

Test Plan:
- Reset release, mem_gnt=1 always, rvalid one cycle after grant, instr_ready=1 → mem_addr sequence 0x3000,0x3004,0x3008…; instr_pc matches in order; instr equals the memory contents; sustained throughput 1 instr/cycle.
- instr_ready=0, DEPTH=4 → exactly 4 grants (0x3000–0x300C), then mem_req=0. Set instr_ready=1 for one pop → exactly one more request at 0x3010 the following cycle.
- Two requests in flight (0x3000, 0x3004 granted, unanswered), redirect_pc=0x4002 → next mem_addr=0x4000. Both late responses are discarded (drop 2→0). First instr_pc seen=0x4000.
- Redirect in the same cycle as mem_rvalid and instr_valid&&instr_ready with 1 live → that response is dropped, drop=0 afterwards, no instruction delivered that cycle, fetch restarts at the redirect address.
- mem_gnt held low 5 cycles with mem_req=1 → mem_addr stable at 0x3000 throughout. fetch_pc=0xFFFFFFFC granted → next mem_addr=0x00000000.
- Assert reset low mid-stream (FIFO 3 entries, 1 live) → asynchronously instr_valid=0, mem_req=0. After release, first mem_addr=0x3000.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//
// Instruction-fetch front end. Walks the sequential fetch address stream and
// issues in-order word requests to instruction memory over a req/gnt plus
// rvalid interface. Returned words are tagged with their PC and buffered in a
// DEPTH-entry FIFO, which decode drains through a valid/ready handshake.
// A redirect flushes the buffer, marks every in-flight response for discard
// and restarts fetch at the new PC.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   redirect_valid redirect request this cycle (highest priority)
//   redirect_pc    new fetch address, bits [1:0] ignored
//   mem_req        fetch request valid
//   mem_addr       fetch word address
//   mem_gnt        request accepted when mem_req && mem_gnt
//   mem_rvalid     response valid, one per grant, in order
//   mem_rdata      returned instruction word
//   instr_valid    instruction available at FIFO head
//   instr          instruction word at FIFO head (zero when empty)
//   instr_pc       PC of instr (zero when empty)
//   instr_ready    decode accepts when instr_valid && instr_ready
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // Architectural state
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [CW-1:0] live, live_n;
    logic [CW-1:0] drop, drop_n;
    logic [CW-1:0] count, count_n;

    // Tag FIFO: PCs of granted requests whose responses are still wanted.
    // Its occupancy always equals live, so no separate counter is kept.
    logic [31:0]   tag_mem [DEPTH];
    logic [PW-1:0] tag_wr, tag_wr_n;
    logic [PW-1:0] tag_rd, tag_rd_n;

    // Instruction FIFO: {pc, word} pairs waiting for decode
    logic [31:0]   dat_pc   [DEPTH];
    logic [31:0]   dat_word [DEPTH];
    logic [PW-1:0] dat_wr, dat_wr_n;
    logic [PW-1:0] dat_rd, dat_rd_n;

    logic [SW-1:0] credits_used;
    logic          grant;
    logic          resp_keep;
    logic          resp_drop;
    logic          pop;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Every granted, buffered or to-be-dropped fetch holds one credit, which
    // is what keeps the FIFO from ever overflowing when a response lands.
    // Gating with reset keeps the outputs quiet while reset is held.
    always_comb begin
        credits_used = SW'(live) + SW'(drop) + SW'(count);
        mem_req      = reset && !redirect_valid && (credits_used < DEPTH_S);
        mem_addr     = fetch_pc;
        grant        = mem_req && mem_gnt;
        resp_keep    = mem_rvalid && (drop == '0);
        resp_drop    = mem_rvalid && (drop != '0);
        instr_valid  = reset && (count != '0) && !redirect_valid;
        pop          = instr_valid && instr_ready;
        instr        = (count != '0) ? dat_word[dat_rd] : 32'h0;
        instr_pc     = (count != '0) ? dat_pc[dat_rd]   : 32'h0;
    end

    // Next-state logic. A redirect overrides every other update; responses
    // still owed for live requests are turned into drops, minus the one
    // (if any) that arrives and is discarded in the redirect cycle itself.
    always_comb begin
        fetch_pc_n = fetch_pc;
        live_n     = live;
        drop_n     = drop;
        count_n    = count;
        tag_wr_n   = tag_wr;
        tag_rd_n   = tag_rd;
        dat_wr_n   = dat_wr;
        dat_rd_n   = dat_rd;
        if (redirect_valid) begin
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            live_n     = '0;
            drop_n     = mem_rvalid ? (drop + live - ONE_C) : (drop + live);
            count_n    = '0;
            tag_wr_n   = '0;
            tag_rd_n   = '0;
            dat_wr_n   = '0;
            dat_rd_n   = '0;
        end else begin
            if (grant) begin
                fetch_pc_n = fetch_pc + 32'd4;
                tag_wr_n   = tag_wr + ONE_P;
            end
            if (grant && !resp_keep) begin
                live_n = live + ONE_C;
            end else if (!grant && resp_keep) begin
                live_n = live - ONE_C;
            end
            if (resp_drop) begin
                drop_n = drop - ONE_C;
            end
            if (resp_keep) begin
                tag_rd_n = tag_rd + ONE_P;
                dat_wr_n = dat_wr + ONE_P;
            end
            if (pop) begin
                dat_rd_n = dat_rd + ONE_P;
            end
            if (resp_keep && !pop) begin
                count_n = count + ONE_C;
            end else if (!resp_keep && pop) begin
                count_n = count - ONE_C;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            live     <= '0;
            drop     <= '0;
            count    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            dat_wr   <= '0;
            dat_rd   <= '0;
        end else begin
            fetch_pc <= fetch_pc_n;
            live     <= live_n;
            drop     <= drop_n;
            count    <= count_n;
            tag_wr   <= tag_wr_n;
            tag_rd   <= tag_rd_n;
            dat_wr   <= dat_wr_n;
            dat_rd   <= dat_rd_n;
        end
    end

    // FIFO storage needs no reset: the pointers and counters decide what is
    // visible, and empty entries are masked to zero at the outputs.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
        if (resp_keep && !redirect_valid) begin
            dat_pc[dat_wr]   <= tag_mem[tag_rd];
            dat_word[dat_wr] <= mem_rdata;
        end
    end

endmodule
